alu_issue_stage: RTL and testbench

// - Issue stage directly upstream of the ALU result mux (4-bit select: 0010 SUM, 0110 SUB, 0000 AND, 0001 OR, other -> 0).
// - Decodes ALUOp/funct3/funct7[5] into that 4-bit select.
// - Chooses operand B (rs2 or imm) and registers operands and select toward the ALU/mux.
// - Valid/ready handshake on both sides with a 2-entry skid buffer, so in_ready is a register output.

---
 rtl/alu_issue_stage.sv | 142 ++++++++++++++
 tb/tb_alu_issue_stage.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ALU issue stage: select decode, operand B mux, 2-entry skid-buffered handshake
module alu_issue_stage #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] rs1_data,
    input  logic [N-1:0] rs2_data,
    input  logic [N-1:0] imm,
    input  logic         alu_src,
    input  logic [1:0]   alu_op,
    input  logic [2:0]   funct3,
    input  logic         funct7b5,
    input  logic         is_rtype,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] op_a,
    output logic [N-1:0] op_b,
    output logic [3:0]   alu_sel,
    output logic         illegal
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t       state, state_nxt;
    logic [3:0]   dec_sel;
    logic         dec_ill;
    logic [N-1:0] b_mux;
    logic         accept, consume;
    logic         load_new, load_skid, load_from_skid;
    logic [N-1:0] skid_a, skid_b;
    logic [3:0]   skid_sel;
    logic         skid_ill;

    always_comb begin
        dec_sel = 4'b1111;
        dec_ill = 1'b1;
        case (alu_op)
            2'b00: begin dec_sel = 4'b0010; dec_ill = 1'b0; end
            2'b01: begin dec_sel = 4'b0110; dec_ill = 1'b0; end
            2'b10: begin
                case (funct3)
                    3'b000: begin
                        dec_sel = (is_rtype && funct7b5) ? 4'b0110 : 4'b0010;
                        dec_ill = 1'b0;
                    end
                    3'b111: begin dec_sel = 4'b0000; dec_ill = 1'b0; end
                    3'b110: begin dec_sel = 4'b0001; dec_ill = 1'b0; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign b_mux     = alu_src ? imm : rs2_data;
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    always_comb begin
        state_nxt      = state;
        load_new       = 1'b0;
        load_skid      = 1'b0;
        load_from_skid = 1'b0;
        case (state)
            EMPTY: if (accept) begin
                state_nxt = ONE;
                load_new  = 1'b1;
            end
            ONE: begin
                if (accept && consume) begin
                    load_new = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = TWO;
                end else if (consume) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: if (consume) begin
                load_from_skid = 1'b1;
                state_nxt      = ONE;
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush wins over any same-cycle transfer; the incoming entry is dropped.
        if (flush) begin
            state_nxt      = EMPTY;
            load_new       = 1'b0;
            load_skid      = 1'b0;
            load_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != TWO);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a     <= '0;
            op_b     <= '0;
            alu_sel  <= 4'b1111;
            illegal  <= 1'b0;
            skid_a   <= '0;
            skid_b   <= '0;
            skid_sel <= 4'b1111;
            skid_ill <= 1'b0;
        end else begin
            if (flush) begin
                alu_sel <= 4'b1111;
            end else if (load_new) begin
                op_a    <= rs1_data;
                op_b    <= b_mux;
                alu_sel <= dec_sel;
                illegal <= dec_ill;
            end else if (load_from_skid) begin
                op_a    <= skid_a;
                op_b    <= skid_b;
                alu_sel <= skid_sel;
                illegal <= skid_ill;
            end
            if (load_skid) begin
                skid_a   <= rs1_data;
                skid_b   <= b_mux;
                skid_sel <= dec_sel;
                skid_ill <= dec_ill;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] rs1_data, rs2_data, imm;
    logic         alu_src;
    logic [1:0]   alu_op;
    logic [2:0]   funct3;
    logic         funct7b5, is_rtype;
    logic         out_valid, out_ready;
    logic [N-1:0] op_a, op_b;
    logic [3:0]   alu_sel;
    logic         illegal;

    int n_checks = 0;
    int n_pass   = 0;

    alu_issue_stage #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .alu_src(alu_src), .alu_op(alu_op), .funct3(funct3),
        .funct7b5(funct7b5), .is_rtype(is_rtype),
        .out_valid(out_valid), .out_ready(out_ready),
        .op_a(op_a), .op_b(op_b), .alu_sel(alu_sel), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] op, input logic [2:0] f3,
                          input logic f7, input logic rt);
        alu_op = op; funct3 = f3; funct7b5 = f7; is_rtype = rt;
    endtask

    // Send one entry with out_ready=1 and check the decoded select.
    task automatic decode_one(input string tag, input logic [1:0] op, input logic [2:0] f3,
                              input logic f7, input logic rt,
                              input logic [3:0] exp_sel, input logic exp_ill);
        set_op(op, f3, f7, rt);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_sel"}, alu_sel, exp_sel);
        check({tag, "_ill"}, illegal, exp_ill);
        step();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        rs1_data = 8'h12; rs2_data = 8'h34; imm = 8'hF0; alu_src = 1'b0;
        set_op(2'b00, 3'b000, 1'b0, 1'b0);
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 1);
        check("rst_sel", alu_sel, 4'hF);
        check("rst_opa", op_a, 0);
        check("rst_ill", illegal, 0);
        rst_n = 1'b1;
        step();

        decode_one("r_sub",  2'b10, 3'b000, 1'b1, 1'b1, 4'b0110, 1'b0);
        decode_one("i_add",  2'b10, 3'b000, 1'b1, 1'b0, 4'b0010, 1'b0);
        decode_one("and",    2'b10, 3'b111, 1'b0, 1'b1, 4'b0000, 1'b0);
        decode_one("or",     2'b10, 3'b110, 1'b0, 1'b1, 4'b0001, 1'b0);
        decode_one("ldst",   2'b00, 3'b100, 1'b1, 1'b1, 4'b0010, 1'b0);
        decode_one("branch", 2'b01, 3'b001, 1'b0, 1'b0, 4'b0110, 1'b0);
        decode_one("f3_100", 2'b10, 3'b100, 1'b0, 1'b1, 4'b1111, 1'b1);
        decode_one("op_11",  2'b11, 3'b000, 1'b0, 1'b0, 4'b1111, 1'b1);

        // Operand mux
        set_op(2'b00, 3'b000, 1'b0, 1'b0);
        alu_src = 1'b0; in_valid = 1'b1;
        step();
        check("mux0_a", op_a, 8'h12);
        check("mux0_b", op_b, 8'h34);
        alu_src = 1'b1;
        step();
        in_valid = 1'b0;
        check("mux1_a", op_a, 8'h12);
        check("mux1_b", op_b, 8'hF0);
        step();
        check("mux_drain", out_valid, 0);
        alu_src = 1'b0;

        // Backpressure: A then B with out_ready low
        out_ready = 1'b0;
        rs1_data = 8'hA1; in_valid = 1'b1;
        step();
        check("bp_a_valid", out_valid, 1);
        check("bp_a_ready", in_ready, 1);
        rs1_data = 8'hB2;
        step();
        in_valid = 1'b0;
        check("bp_full_ready", in_ready, 0);
        check("bp_hold_a", op_a, 8'hA1);
        step();
        check("bp_hold_a2", op_a, 8'hA1);
        check("bp_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        step();
        check("bp_b_out", op_a, 8'hB2);
        check("bp_b_valid", out_valid, 1);
        check("bp_ready_back", in_ready, 1);
        step();
        check("bp_drain", out_valid, 0);

        // Streaming: 16 back-to-back
        for (int i = 0; i < 16; i++) begin
            rs1_data = 8'(i + 8'h40); in_valid = 1'b1;
            step();
            check($sformatf("st_a%0d", i), op_a, i + 8'h40);
            check($sformatf("st_v%0d", i), {out_valid, in_ready}, 2'b11);
        end
        in_valid = 1'b0;
        step();
        check("st_drain", out_valid, 0);

        // Flush while TWO with in_valid held high
        out_ready = 1'b0;
        rs1_data = 8'hC1; in_valid = 1'b1;
        step();
        rs1_data = 8'hC2;
        step();
        check("fl_two_ready", in_ready, 0);
        flush = 1'b1; rs1_data = 8'hC3;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", out_valid, 0);
        check("fl_ready", in_ready, 1);
        check("fl_sel", alu_sel, 4'hF);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("fl_nostale%0d", i), out_valid, 0);
        end

        // Async reset mid-stream
        out_ready = 1'b0;
        set_op(2'b01, 3'b000, 1'b0, 1'b0);
        rs1_data = 8'hD1; in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        check("ar_pre_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_ready", in_ready, 1);
        check("ar_sel", alu_sel, 4'hF);
        #3 rst_n = 1'b1;
        step();
        check("ar_after", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
